// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: default widths, the reset fetch address and
// the fetch FIFO entry layout {instr, pc}.
package fetch_unit_pkg;

  localparam int unsigned FETCH_DATA_WIDTH      = 32;
  localparam int unsigned FETCH_IMEM_ADDR_WIDTH = 10;
  localparam int unsigned FETCH_PC_WIDTH        = 32;
  localparam logic [FETCH_PC_WIDTH-1:0] FETCH_RESET_PC = 32'h0;

  // Default-width FIFO entry; fetch_unit derives its own copy when widths differ.
  typedef struct packed {
    logic [FETCH_DATA_WIDTH-1:0] instr;
    logic [FETCH_PC_WIDTH-1:0]   pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: imem request/response, redirect from execute and the
// valid/ready instruction stream toward decode.
//  master : fetch unit side (drives imem_address, instr_valid, instr, instr_pc)
//  slave  : environment side (imem, execute, decode)
interface fetch_unit_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned PC_WIDTH   = 32
) ();

  logic [ADDR_WIDTH-1:0] imem_address;
  logic [DATA_WIDTH-1:0] imem_read_data;
  logic                  imem_read_data_valid;
  logic                  redirect_valid;
  logic [PC_WIDTH-1:0]   redirect_pc;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [DATA_WIDTH-1:0] instr;
  logic [PC_WIDTH-1:0]   instr_pc;

  modport master (
    output imem_address,
    input  imem_read_data,
    input  imem_read_data_valid,
    input  redirect_valid,
    input  redirect_pc,
    output instr_valid,
    input  instr_ready,
    output instr,
    output instr_pc
  );

  modport slave (
    input  imem_address,
    output imem_read_data,
    output imem_read_data_valid,
    output redirect_valid,
    output redirect_pc,
    input  instr_valid,
    output instr_ready,
    input  instr,
    input  instr_pc
  );

endinterface

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: synchronous circular FIFO of entry_t with flush.
//  clk, rst_n : clock, asynchronous active-low reset
//  push/push_data : write an entry (caller guarantees space)
//  pop        : drop the head (caller guarantees non-empty)
//  flush      : empty the FIFO; wins over push/pop
//  count      : number of stored entries
//  head       : entry at the read pointer (all-zero after reset)
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter type         entry_t = fetch_entry_t
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  entry_t                     push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output entry_t                     head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of a 1-cycle registered imem.
// Owns the PC, issues one word address per cycle when the output FIFO has room
// reserved, captures the returned word the following cycle, and replays the
// fetch if imem flags the data invalid. A redirect squashes everything.
//  clk, rst_n : clock, asynchronous active-low reset
//  bus        : fetch_unit_if.master (imem, redirect, decode handshake)
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned         DATA_WIDTH = FETCH_DATA_WIDTH,
  parameter int unsigned         ADDR_WIDTH = FETCH_IMEM_ADDR_WIDTH,
  parameter int unsigned         PC_WIDTH   = FETCH_PC_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(FETCH_RESET_PC),
  parameter int unsigned         FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_unit_if.master  bus
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH+1);
  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH+2);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]   pc;
  } entry_t;

  logic [PC_WIDTH-1:0] pc_issue;
  logic                inflight;
  logic [PC_WIDTH-1:0] inflight_pc;

  logic [CNT_W-1:0]    count;
  entry_t              head;
  entry_t              push_data;
  logic                pop;
  logic                capture;
  logic                push;
  logic                replay;
  logic                issue;
  logic [OCC_W-1:0]    occ;

  logic                unused_pc_lsbs;
  assign unused_pc_lsbs = ^bus.redirect_pc[1:0];

  assign bus.imem_address = pc_issue[ADDR_WIDTH+1:2];
  assign bus.instr_valid  = (count != '0) & ~bus.redirect_valid;
  assign bus.instr        = head.instr;
  assign bus.instr_pc     = head.pc;

  // Occupancy counts the in-flight fetch so a capture always finds a free slot.
  always_comb begin
    pop       = bus.instr_valid & bus.instr_ready;
    capture   = inflight & ~bus.redirect_valid;
    push      = capture & bus.imem_read_data_valid;
    replay    = capture & ~bus.imem_read_data_valid;
    occ       = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);
    issue     = ~bus.redirect_valid & ~replay & (occ < OCC_W'(FIFO_DEPTH));
    push_data = '{instr: bus.imem_read_data, pc: inflight_pc};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_issue    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (bus.redirect_valid) begin
      pc_issue <= {bus.redirect_pc[PC_WIDTH-1:2], 2'b00};
      inflight <= 1'b0;
    end else if (replay) begin
      // Rewind to the dropped fetch; it is reissued next cycle.
      pc_issue <= inflight_pc;
      inflight <= 1'b0;
    end else if (issue) begin
      inflight    <= 1'b1;
      inflight_pc <= pc_issue;
      pc_issue    <= pc_issue + PC_WIDTH'(4);
    end else begin
      inflight <= 1'b0;
    end
  end

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (bus.redirect_valid),
    .count     (count),
    .head      (head)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit with a 16-word imem (ADDR_WIDTH=4), imem[k]=k.
// Each table row gives one cycle of inputs and the outputs expected in that
// cycle; rows flagged rst apply an asynchronous reset first.
module tb_fetch_unit;

  localparam int unsigned AW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .PC_WIDTH(32)) bus ();

  fetch_unit #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (AW),
    .PC_WIDTH   (32),
    .RESET_PC   (32'h0),
    .FIFO_DEPTH (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [16];
  always @(posedge clk) bus.imem_read_data <= mem[bus.imem_address];

  typedef struct {
    bit          rst;
    bit          rdy;
    bit          rv;
    logic [31:0] rpc;
    bit          dv;
    logic [3:0]  addr;
    bit          valid;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void add(input bit r, input bit rdy, input bit rv, input logic [31:0] rpc,
                              input bit dv, input logic [3:0] a, input bit val, input logic [31:0] pc);
    vec_t v;
    v.rst = r; v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.dv = dv;
    v.addr = a; v.valid = val; v.pc = pc;
    vecs.push_back(v);
  endfunction

  // Free-running stream from reset with decode always ready.
  function automatic void add_stream(input int unsigned n);
    for (int unsigned k = 0; k < n; k++)
      add(k == 0, 1'b1, 1'b0, 32'h0, 1'b1, 4'(k), k >= 2, (k >= 2) ? 32'((k - 2) * 4) : 32'h0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    bus.instr_ready          = 1'b0;
    bus.redirect_valid       = 1'b0;
    bus.redirect_pc          = '0;
    bus.imem_read_data_valid = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = 32'(i);

    // Test 1: basic streaming, then mid-stream async reset on the next rst row.
    add_stream(6);
    // Test 2: stall five cycles with head frozen at 0x0, then release.
    add(1,1,0,0,1, 0,0,0);
    add(0,1,0,0,1, 1,0,0);
    for (int i = 0; i < 5; i++) add(0,0,0,0,1, 2,1,0);
    add(0,1,0,0,1, 2,1,32'h0);
    add(0,1,0,0,1, 3,1,32'h4);
    add(0,1,0,0,1, 4,1,32'h8);
    add(0,1,0,0,1, 5,1,32'hC);
    // Test 5: imem data invalid in the capture cycle of 0x8 -> replay.
    add(1,1,0,0,1, 0,0,0);
    add(0,1,0,0,1, 1,0,0);
    add(0,1,0,0,1, 2,1,32'h0);
    add(0,1,0,0,0, 3,1,32'h4);
    add(0,1,0,0,1, 2,0,0);
    add(0,1,0,0,1, 3,0,0);
    add(0,1,0,0,1, 4,1,32'h8);
    add(0,1,0,0,1, 5,1,32'hC);
    // Tests 3/4: redirects with buffered + in-flight work, unaligned target, back-to-back.
    add(1,0,0,0,1, 0,0,0);
    add(0,0,0,0,1, 1,0,0);
    add(0,0,1,32'h40,1, 2,0,0);
    add(0,1,0,0,1, 0,0,0);
    add(0,1,0,0,1, 1,0,0);
    add(0,1,0,0,1, 2,1,32'h40);
    add(0,1,0,0,1, 3,1,32'h44);
    add(0,1,1,32'h43,1, 4,0,0);
    add(0,1,0,0,1, 0,0,0);
    add(0,1,0,0,1, 1,0,0);
    add(0,1,0,0,1, 2,1,32'h40);
    add(0,1,1,32'h80,1, 3,0,0);
    add(0,1,1,32'h100,1, 0,0,0);
    add(0,1,0,0,1, 0,0,0);
    add(0,1,0,0,1, 1,0,0);
    add(0,1,0,0,1, 2,1,32'h100);
    add(0,1,0,0,1, 3,1,32'h104);
    // Test 6: 20 fetches, imem word address wraps 15->0 while PC keeps counting.
    add_stream(22);

    #6;
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      if (v.rst) begin
        rst_n = 1'b0;
        #1;
        check($sformatf("row%0d reset instr_valid", i), 32'(bus.instr_valid), 32'h0);
        check($sformatf("row%0d reset instr", i),       bus.instr,            32'h0);
        check($sformatf("row%0d reset instr_pc", i),    bus.instr_pc,         32'h0);
        check($sformatf("row%0d reset imem_address", i), 32'(bus.imem_address), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
      bus.instr_ready          = v.rdy;
      bus.redirect_valid       = v.rv;
      bus.redirect_pc          = v.rpc;
      bus.imem_read_data_valid = v.dv;
      @(negedge clk);
      check($sformatf("row%0d imem_address", i), 32'(bus.imem_address), 32'(v.addr));
      check($sformatf("row%0d instr_valid", i),  32'(bus.instr_valid),  32'(v.valid));
      if (v.valid) begin
        check($sformatf("row%0d instr_pc", i), bus.instr_pc, v.pc);
        check($sformatf("row%0d instr", i),    bus.instr,    (v.pc >> 2) & 32'hF);
      end
      @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
